// File: rtl/div_iter.sv
// ============================================================================
// Module  : div_iter
// Brief   : 32-bit signed iterative restoring divider, one quotient bit/cycle.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module div_iter (
  input  logic        clk,
  input  logic        clr,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic        neg_q, neg_d;
  logic        zero_q, zero_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
  logic        rdy_q, rdy_d;

  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_rem_shift;
  logic        w_fits;
  logic [31:0] w_diff;

  // Unsigned magnitudes: 0x80000000 negates to itself, read as 2^31.
  assign w_a_mag     = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
  assign w_b_mag     = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;
  assign w_rem_shift = {rem_q, dvd_q[31]};
  assign w_fits      = (w_rem_shift >= {1'b0, dvs_q});
  assign w_diff      = w_rem_shift[31:0] - dvs_q;

  // State register plus datapath registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      dvd_q    <= 32'd0;
      dvs_q    <= 32'd0;
      quo_q    <= 32'd0;
      rem_q    <= 32'd0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      result_q <= 32'd0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  // Next-state logic; a start pulse overrides every state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_IDLE;
      S_BUSY:  if (cnt_q == 5'd31) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (ctrl_DIV) state_d = S_BUSY;
  end

  // Datapath and output logic.
  always_comb begin
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    neg_d    = neg_q;
    zero_d   = zero_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    if (ctrl_DIV) begin
      cnt_d  = 5'd0;
      dvd_d  = w_a_mag;
      dvs_d  = w_b_mag;
      quo_d  = 32'd0;
      rem_d  = 32'd0;
      neg_d  = data_operandA[31] ^ data_operandB[31];
      zero_d = (data_operandB == 32'd0);
    end else begin
      case (state_q)
        S_BUSY: begin
          dvd_d = {dvd_q[30:0], 1'b0};
          quo_d = {quo_q[30:0], w_fits};
          rem_d = w_fits ? w_diff : w_rem_shift[31:0];
          if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
        end
        S_DONE: begin
          // A zero divisor leaves an all-ones quotient; report 0 instead.
          if (zero_q)     result_d = 32'd0;
          else if (neg_q) result_d = ~quo_q + 32'd1;
          else            result_d = quo_q;
          exc_d = zero_q;
          rdy_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule

`default_nettype wire

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 Port list, one per line (name  direction  width  meaning):
- clk  input  1  rising-edge clock
- clr  input  1  asynchronous active-high reset
- ctrl_DIV  input  1  start pulse; operands sampled on the edge where it is 1
- data_operandA  input  32  signed dividend
- data_operandB  input  32  signed divisor
- data_result  output  32  signed quotient, truncated toward zero
- data_exception  output  1  divide-by-zero flag, valid with data_resultRDY
- data_resultRDY  output  1  one-cycle completion strobe
REQ-003 SHALL have no parameters; all widths are fixed at 32 bits for data and 5 bits for the internal iteration count.

Function
REQ-004 FSM states: IDLE, BUSY, DONE; encoding is free.
REQ-005 Any state, ctrl_DIV=1 at an edge: latch |A|, |B|, sign(A) XOR sign(B), and (B==0); clear quotient/partial remainder; iteration count := 0; next state BUSY.
REQ-006 Operands SHALL be sampled only at the start edge; later changes are ignored.
REQ-007 BUSY: one restoring-division step per edge, MSB first.
- Step: shift remainder left and bring in the next dividend bit.
- Trial-subtract |B|.
- If non-negative, keep the difference and set quotient bit to 1; else restore and set quotient bit to 0.
- Iteration count increments by 1 per step, 0 through 31.
REQ-008 The step at count 31 SHALL transition BUSY -> DONE; the count SHALL NOT wrap back into another step.
REQ-009 DONE, on entry edge+1 (the DONE -> IDLE edge):
- data_result := quotient, two's-complement negated if the latched sign flag = 1.
- data_exception := latched zero flag.
- data_resultRDY := 1.
- Next state IDLE.
REQ-010 data_resultRDY SHALL be 1 for exactly one cycle per completed operation, 33 rising edges after the start edge.
REQ-011 Divide by zero: data_result := 0x00000000 and data_exception := 1, with the same 33-edge latency.
REQ-012 0x80000000 / 0xFFFFFFFF: data_result := 0x80000000 (wrap), data_exception := 0.
REQ-013 |A| and |B| SHALL be computed at 33-bit-safe width so that 0x80000000 yields magnitude 2^31.
REQ-014 ctrl_DIV=1 while BUSY or DONE: abort the current operation and restart per REQ-005; no data_resultRDY for the aborted operation.
REQ-015 ctrl_DIV=1 on the same edge data_resultRDY would rise (in DONE): the restart wins, no strobe is issued, and data_result/data_exception are not updated.
REQ-016 data_result and data_exception SHALL hold their last values outside DONE -> IDLE updates, including while BUSY.
REQ-017 IDLE with ctrl_DIV=0: all registers hold; data_resultRDY = 0.

Reset
REQ-018 clr=1 SHALL immediately force the following, independent of clk:
- state IDLE
- iteration count 0
- quotient, remainder and operand registers 0
- data_result 0x00000000
- data_exception 0
- data_resultRDY 0
REQ-019 clr asserted mid-operation SHALL discard the operation; no data_resultRDY follows deassertion.
REQ-020 ctrl_DIV SHALL be ignored while clr=1.

Verification
REQ-021 Positive operands: A=100, B=7 -> data_result 0x0000000E, data_exception 0, data_resultRDY high exactly one cycle, 33 edges after start.
REQ-022 Signed operands, two cases:
- A=-100, B=7 -> 0xFFFFFFF2.
- A=7, B=-100 -> 0x00000000; data_exception 0 in both.
REQ-023 Divide by zero and overflow, two cases:
- A=5, B=0 -> data_result 0x00000000, data_exception 1, same latency.
- A=0x80000000, B=0xFFFFFFFF -> 0x80000000, data_exception 0.
REQ-024 Restart: start 100/7, then ctrl_DIV with 9/3 on edge 10 -> single data_resultRDY 33 edges after the second start, data_result 3; no strobe from the first operation.
REQ-025 Reset mid-operation: start 100/7, pulse clr asynchronously mid-cycle at edge 20 -> outputs 0 immediately; no strobe within 40 subsequent cycles. Then 8/2 -> 4 at the normal latency.
